// File: rtl/xor_stream_cipher_param_if.sv
// Serial load / ciphertext bundle for one cipher tile.
// master drives the load stream; slave is the cipher core.
interface xor_stream_cipher_param_if;
  logic en;
  logic data_in;
  logic load_key;
  logic load_msg;
  logic mode;
  logic clk_slow;
  logic data_out;
  logic valid;
  logic done_flag;

  modport master (
    output en, data_in, load_key, load_msg, mode,
    input  clk_slow, data_out, valid, done_flag
  );

  modport slave (
    input  en, data_in, load_key, load_msg, mode,
    output clk_slow, data_out, valid, done_flag
  );
endinterface

// File: rtl/xor_stream_cipher_param.sv
// Bit-serial XOR stream cipher: key/message shifted in MSB first, ciphertext
// shifted out on divided ticks; keystream is the repeating key or a key-seeded LFSR.
module xor_stream_cipher_param #(
  parameter int               KEY_W = 8,
  parameter int               MSG_W = 8,
  parameter int               DIV   = 4,
  parameter logic [KEY_W-1:0] TAPS  = 8'hB8
) (
  input  logic                      clk,
  input  logic                      rst,
  xor_stream_cipher_param_if.slave  bus
);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(((KEY_W > MSG_W) ? KEY_W : MSG_W) + 1);

  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_MSG, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [KEY_W-1:0] key, key_n, ks, ks_n;
  logic [MSG_W-1:0] msg, msg_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic             key_valid, key_valid_n, msg_valid, msg_valid_n;
  logic             mode_r, mode_n;
  logic             dout, dout_n, valid, valid_n, done, done_n;

  // divider free-runs regardless of enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= (cnt == CW'(DIV-1)) ? '0 : cnt + 1'b1;
  end

  assign tick          = (cnt == CW'(DIV-1));
  assign bus.clk_slow  = (cnt >= CW'(DIV/2));
  assign bus.data_out  = dout;
  assign bus.valid     = valid;
  assign bus.done_flag = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key       <= '0;
      msg       <= '0;
      ks        <= '0;
      bitcnt    <= '0;
      key_valid <= 1'b0;
      msg_valid <= 1'b0;
      mode_r    <= 1'b0;
      dout      <= 1'b0;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      key       <= key_n;
      msg       <= msg_n;
      ks        <= ks_n;
      bitcnt    <= bitcnt_n;
      key_valid <= key_valid_n;
      msg_valid <= msg_valid_n;
      mode_r    <= mode_n;
      dout      <= dout_n;
      valid     <= valid_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    key_n       = key;
    msg_n       = msg;
    ks_n        = ks;
    bitcnt_n    = bitcnt;
    key_valid_n = key_valid;
    msg_valid_n = msg_valid;
    mode_n      = mode_r;
    dout_n      = dout;
    valid_n     = valid;
    done_n      = done;
    if (!bus.en) valid_n = 1'b0;
    if (tick && bus.en) begin
      case (state)
        IDLE: begin
          if (bus.load_key) begin
            key_n       = {key[KEY_W-2:0], bus.data_in};
            key_valid_n = 1'b0;
            bitcnt_n    = BW'(1);
            state_n     = LOAD_KEY;
          end else if (bus.load_msg) begin
            msg_n       = MSG_W'({msg, bus.data_in});
            msg_valid_n = (MSG_W == 1);
            if (MSG_W > 1) begin
              bitcnt_n = BW'(1);
              state_n  = LOAD_MSG;
            end
          end else if (key_valid && msg_valid) begin
            mode_n   = bus.mode;
            // an all-zero LFSR would lock up, so it is seeded with 1 instead
            ks_n     = (bus.mode && key == '0) ? KEY_W'(1) : key;
            bitcnt_n = '0;
            state_n  = RUN;
          end
        end
        LOAD_KEY: begin
          if (!bus.load_key) begin
            key_n       = '0;
            key_valid_n = 1'b0;
            bitcnt_n    = '0;
            state_n     = IDLE;
          end else begin
            key_n = {key[KEY_W-2:0], bus.data_in};
            if (bitcnt == BW'(KEY_W-1)) begin
              key_valid_n = 1'b1;
              bitcnt_n    = '0;
              state_n     = IDLE;
            end else begin
              bitcnt_n = bitcnt + 1'b1;
            end
          end
        end
        LOAD_MSG: begin
          if (!bus.load_msg) begin
            msg_n       = '0;
            msg_valid_n = 1'b0;
            bitcnt_n    = '0;
            state_n     = IDLE;
          end else begin
            msg_n = MSG_W'({msg, bus.data_in});
            if (bitcnt == BW'(MSG_W-1)) begin
              msg_valid_n = 1'b1;
              bitcnt_n    = '0;
              state_n     = IDLE;
            end else begin
              bitcnt_n = bitcnt + 1'b1;
            end
          end
        end
        RUN: begin
          dout_n  = msg[MSG_W-1] ^ ks[KEY_W-1];
          valid_n = 1'b1;
          msg_n   = msg << 1;
          ks_n    = mode_r ? {ks[KEY_W-2:0], ^(ks & TAPS)} : {ks[KEY_W-2:0], ks[KEY_W-1]};
          if (bitcnt == BW'(MSG_W-1)) begin
            bitcnt_n = '0;
            state_n  = DONE;
          end else begin
            bitcnt_n = bitcnt + 1'b1;
          end
        end
        DONE: begin
          // first DONE tick leaves the last ciphertext bit its full hold time
          if (!done) begin
            done_n      = 1'b1;
            valid_n     = 1'b0;
            msg_valid_n = 1'b0;
          end else if (bus.load_key || bus.load_msg) begin
            done_n  = 1'b0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (tick && state == DONE && done) begin
      done_n  = 1'b0;
      state_n = IDLE;
    end
  end
endmodule

// File: tb/tb_xor_stream_cipher_param.sv
// Bench for xor_stream_cipher_param: two instances (8- and 16-bit messages)
// checked every cycle against a keystream model and a few literal results.
module tb_xor_stream_cipher_param;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_stream_cipher_param_if ifa();
  xor_stream_cipher_param_if ifb();

  xor_stream_cipher_param #(.KEY_W(8), .MSG_W(8), .DIV(DIV), .TAPS(8'hB8))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  xor_stream_cipher_param #(.KEY_W(8), .MSG_W(16), .DIV(DIV), .TAPS(8'hB8))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic en_s[2], din_s[2], lk_s[2], lm_s[2], md_s[2];
  logic vo[2], dout[2], dn[2], cs[2];

  assign ifa.en = en_s[0]; assign ifa.data_in = din_s[0];
  assign ifa.load_key = lk_s[0]; assign ifa.load_msg = lm_s[0]; assign ifa.mode = md_s[0];
  assign ifb.en = en_s[1]; assign ifb.data_in = din_s[1];
  assign ifb.load_key = lk_s[1]; assign ifb.load_msg = lm_s[1]; assign ifb.mode = md_s[1];
  assign vo[0] = ifa.valid; assign dout[0] = ifa.data_out;
  assign dn[0] = ifa.done_flag; assign cs[0] = ifa.clk_slow;
  assign vo[1] = ifb.valid; assign dout[1] = ifb.data_out;
  assign dn[1] = ifb.done_flag; assign cs[1] = ifb.clk_slow;

  int checks = 0;
  int errors = 0;
  int tb_cnt;
  bit expb0[$];
  bit expb1[$];
  int rd[2];
  logic [15:0] cap[2];
  int ncap[2];
  logic lastbit[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference divider phase
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == DIV-1) ? 0 : tb_cnt + 1;
  end

  // keystream reference: repeating key bits, or the LFSR state sequence
  function automatic logic [15:0] model(input logic [7:0] key, input logic [15:0] msg,
                                        input int w, input bit md);
    logic [7:0]  st [0:15];
    logic [15:0] res;
    logic        kb;
    res   = '0;
    st[0] = (md && key == 8'h00) ? 8'h01 : key;
    for (int i = 0; i < 15; i++) st[i+1] = {st[i][6:0], ^(st[i] & 8'hB8)};
    for (int i = 0; i < w; i++) begin
      kb = md ? st[i][7] : key[7 - (i % 8)];
      res[w-1-i] = msg[w-1-i] ^ kb;
    end
    return res;
  endfunction

  // compare process: divider output every cycle, each new bit, and bit hold
  always @(negedge clk) begin
    if (rst) begin
      rd[0] = expb0.size();
      rd[1] = expb1.size();
    end else begin
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("clk_slow%0d", s), 32'(cs[s]), 32'(tb_cnt >= DIV/2));
        if (vo[s] && tb_cnt == 0) begin
          if (rd[s] >= ((s == 0) ? expb0.size() : expb1.size())) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit dut%0d got %0b want no output", s, dout[s]);
          end else begin
            chk($sformatf("cipher_bit%0d", s), 32'(dout[s]),
                32'((s == 0) ? expb0[rd[s]] : expb1[rd[s]]));
            rd[s]++;
          end
          cap[s]     = {cap[s][14:0], dout[s]};
          ncap[s]    = ncap[s] + 1;
          lastbit[s] = dout[s];
        end else if (vo[s]) begin
          chk($sformatf("hold%0d", s), 32'(dout[s]), 32'(lastbit[s]));
        end
      end
    end
  end

  task automatic tick_wait();
    do begin
      @(posedge clk); #1;
    end while (tb_cnt != 0);
  endtask

  task automatic load(input int s, input bit is_key, input logic [15:0] val,
                      input int width, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      din_s[s] = val[width-1-i];
      if (is_key) lk_s[s] = 1'b1; else lm_s[s] = 1'b1;
      tick_wait();
    end
    lk_s[s] = 1'b0;
    lm_s[s] = 1'b0;
  endtask

  task automatic push_exp(input int s, input logic [15:0] e, input int w);
    for (int i = 0; i < w; i++) begin
      if (s == 0) expb0.push_back(e[w-1-i]);
      else        expb1.push_back(e[w-1-i]);
    end
  endtask

  task automatic run(input int s, input logic [7:0] key, input logic [15:0] msg, input bit md,
                     input int pause_at, input bit use_lit, input logic [15:0] lit);
    int w, n0, cyc;
    logic [15:0] e, got;
    w = (s == 0) ? 8 : 16;
    e = model(key, msg, w, md);
    load(s, 1'b1, {8'h00, key}, 8, 8);
    load(s, 1'b0, msg, w, w);
    push_exp(s, e, w);
    n0 = ncap[s];
    md_s[s] = md;
    tick_wait();
    md_s[s] = ~md;
    if (pause_at > 0) begin
      repeat (pause_at) tick_wait();
      en_s[s] = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (k >= 1) chk("valid_paused", 32'(vo[s]), 32'd0);
      end
      en_s[s] = 1'b1;
    end
    cyc = 0;
    while (!dn[s] && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    md_s[s] = 1'b0;
    chk("done_flag", 32'(dn[s]), 32'd1);
    chk("valid_at_done", 32'(vo[s]), 32'd0);
    chk("bit_count", 32'(ncap[s] - n0), 32'(w));
    got = (w == 8) ? {8'h00, cap[s][7:0]} : cap[s];
    chk("cipher_model", 32'(got), 32'(e));
    if (use_lit) chk("cipher_literal", 32'(got), 32'(lit));
    en_s[s] = 1'b0;
    tick_wait();
    en_s[s] = 1'b1;
    chk("done_cleared", 32'(dn[s]), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      en_s[s] = 1'b1; din_s[s] = 1'b0; lk_s[s] = 1'b0; lm_s[s] = 1'b0; md_s[s] = 1'b0;
      ncap[s] = 0; cap[s] = '0; lastbit[s] = 1'b0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", 32'(vo[s]), 32'd0);
      chk("rst_dout", 32'(dout[s]), 32'd0);
      chk("rst_done", 32'(dn[s]), 32'd0);
      chk("rst_clk_slow", 32'(cs[s]), 32'd0);
    end
    #21 rst = 1'b0;

    run(0, 8'hA5, 16'h003C, 1'b0, 0, 1'b1, 16'h0099);
    run(1, 8'hF0, 16'h1234, 1'b0, 0, 1'b1, 16'hE2C4);
    run(0, 8'h01, 16'h00FF, 1'b1, 0, 1'b1, 16'h00FE);
    run(0, 8'h00, 16'h00FF, 1'b1, 0, 1'b1, 16'h00FE);
    run(0, 8'hA5, 16'h003C, 1'b0, 3, 1'b1, 16'h0099);

    // aborted key load: no run may start afterwards
    load(0, 1'b1, 16'h00FF, 8, 3);
    tick_wait();
    load(0, 1'b0, 16'h005A, 8, 8);
    repeat (12) tick_wait();
    chk("abort_valid", 32'(vo[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);

    // asynchronous reset in the middle of a run
    load(0, 1'b1, 16'h00A5, 8, 8);
    load(0, 1'b0, 16'h003C, 8, 8);
    push_exp(0, model(8'hA5, 16'h003C, 8, 1'b0), 8);
    tick_wait();
    repeat (3) tick_wait();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(vo[0]), 32'd0);
    chk("arst_dout", 32'(dout[0]), 32'd0);
    chk("arst_done", 32'(dn[0]), 32'd0);
    chk("arst_clk_slow", 32'(cs[0]), 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    load(0, 1'b0, 16'h003C, 8, 8);
    repeat (12) tick_wait();
    chk("post_rst_no_run", 32'(vo[0]), 32'd0);
    chk("post_rst_no_done", 32'(dn[0]), 32'd0);
    run(0, 8'hA5, 16'h003C, 1'b0, 0, 1'b1, 16'h0099);

    for (int r = 0; r < 8; r++) begin
      logic [7:0]  k;
      logic [15:0] m;
      k = (r == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      m = 16'($urandom_range(0, 65535));
      if ((r % 2) == 0) m[15:8] = 8'h00;
      run(r % 2, k, m, 1'(r / 2), (r == 6) ? 2 : 0, 1'b0, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
